// File: rtl/pbs_pkg.sv
// -----------------------------------------------------------------------------
// pbs_pkg
// Shared definitions for the turn-based battle engine: parameter defaults,
// the battle FSM state encoding, and a helper that classifies the states in
// which the engine is waiting for a new battle.
// No ports (package).
// -----------------------------------------------------------------------------
package pbs_pkg;

  localparam int PBS_HP_W      = 8;
  localparam int PBS_PWR_W     = 6;
  localparam int PBS_STAT_W    = 6;
  localparam int PBS_DMG_SHIFT = 3;
  localparam int PBS_MAX_TURNS = 63;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_PM,
    CALC_PH,
    APPLY_AD,
    LOAD_AM,
    CALC_AH,
    APPLY_PD,
    VICTORY,
    LOSS,
    DRAW
  } pbs_state_t;

  // States in which no battle is running and a new start is honoured.
  function automatic logic is_settled(input pbs_state_t s);
    return (s == IDLE) || (s == VICTORY) || (s == LOSS) || (s == DRAW);
  endfunction

endpackage

// File: rtl/pbs_damage_calc.sv
// -----------------------------------------------------------------------------
// pbs_damage_calc
// Computes and registers the damage of one move:
//   dmg = (power * atk) >> DMG_SHIFT on the full-width product,
//   floored to 1 when power is non-zero but the shifted result is 0,
//   saturated to the largest value an HP register can hold.
// Ports:
//   clk, reset   : clock and synchronous active-high reset (dmg_o -> 0)
//   load_i       : register a new damage value this cycle
//   power_i      : move power of the acting side
//   atk_i        : attack stat of the acting side
//   dmg_o        : registered damage
// -----------------------------------------------------------------------------
module pbs_damage_calc #(
  parameter int HP_W      = 8,
  parameter int PWR_W     = 6,
  parameter int STAT_W    = 6,
  parameter int DMG_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [PWR_W-1:0]  power_i,
  input  logic [STAT_W-1:0] atk_i,
  output logic [HP_W-1:0]   dmg_o
);

  localparam int PROD_W = PWR_W + STAT_W;
  // Wide enough to compare against the HP ceiling whichever of the two is wider.
  localparam int WIDE_W = PROD_W + HP_W;

  logic [PROD_W-1:0] prod;
  logic [HP_W-1:0]   dmg_q;
  logic [HP_W-1:0]   dmg_d;

  function automatic logic [HP_W-1:0] shape_dmg(input logic [PROD_W-1:0] p,
                                                input logic pwr_nz);
    logic [WIDE_W-1:0] shifted;
    logic [WIDE_W-1:0] hp_max;
    shifted = WIDE_W'(p) >> DMG_SHIFT;
    hp_max  = WIDE_W'({HP_W{1'b1}});
    if (shifted == '0) begin
      shape_dmg = pwr_nz ? HP_W'(1) : '0;
    end else if (shifted > hp_max) begin
      shape_dmg = '1;
    end else begin
      shape_dmg = shifted[HP_W-1:0];
    end
  endfunction

  assign prod  = PROD_W'(power_i) * PROD_W'(atk_i);
  assign dmg_d = load_i ? shape_dmg(prod, |power_i) : dmg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dmg_q <= '0;
    end else begin
      dmg_q <= dmg_d;
    end
  end

  assign dmg_o = dmg_q;

endmodule

// File: rtl/pbs_battle_engine.sv
// -----------------------------------------------------------------------------
// pbs_battle_engine
// Turn-based battle controller. A start latches both sides' HP and stats and
// picks the first mover (faster side, ties to the player). Each move is a
// valid/ready handshake followed by a CALC cycle (damage registered) and an
// APPLY cycle (damage event pulsed, target HP reduced). Two moves make a turn;
// after MAX_TURNS turns without a knockout the battle ends in a draw.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   start                       : begin battle (only when not busy)
//   p_hp_init, e_hp_init        : starting HP
//   p_atk, e_atk, p_spd, e_spd  : stats
//   move_valid, move_power,
//   move_ready                  : move handshake
//   p_hp, e_hp                  : current HP
//   dmg_valid, dmg,
//   dmg_to_player               : damage event
//   turn_cnt                    : completed full turns
//   busy, victory, loss, draw   : status
// -----------------------------------------------------------------------------
module pbs_battle_engine
  import pbs_pkg::*;
#(
  parameter int HP_W      = PBS_HP_W,
  parameter int PWR_W     = PBS_PWR_W,
  parameter int STAT_W    = PBS_STAT_W,
  parameter int DMG_SHIFT = PBS_DMG_SHIFT,
  parameter int MAX_TURNS = PBS_MAX_TURNS,
  localparam int TC_W     = $clog2(MAX_TURNS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HP_W-1:0]   p_hp_init,
  input  logic [HP_W-1:0]   e_hp_init,
  input  logic [STAT_W-1:0] p_atk,
  input  logic [STAT_W-1:0] e_atk,
  input  logic [STAT_W-1:0] p_spd,
  input  logic [STAT_W-1:0] e_spd,
  input  logic              move_valid,
  input  logic [PWR_W-1:0]  move_power,
  output logic              move_ready,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   e_hp,
  output logic              dmg_valid,
  output logic [HP_W-1:0]   dmg,
  output logic              dmg_to_player,
  output logic [TC_W-1:0]   turn_cnt,
  output logic              busy,
  output logic              victory,
  output logic              loss,
  output logic              draw
);

  pbs_state_t        state_q, state_d;
  logic [HP_W-1:0]   p_hp_q, p_hp_d;
  logic [HP_W-1:0]   e_hp_q, e_hp_d;
  logic [TC_W-1:0]   turn_q, turn_d;
  logic              enemy_first_q, enemy_first_d;

  logic [STAT_W-1:0] p_atk_q, e_atk_q;
  logic [PWR_W-1:0]  power_q;
  logic              load_ops;
  logic              take_move;

  logic              calc_en;
  logic [STAT_W-1:0] atk_sel;
  logic [HP_W-1:0]   dmg_w;
  logic [TC_W-1:0]   turn_next;

  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                   input logic [HP_W-1:0] d);
    return (hp > d) ? (hp - d) : '0;
  endfunction

  assign calc_en = (state_q == CALC_PH) || (state_q == CALC_AH);
  assign atk_sel = (state_q == CALC_AH) ? e_atk_q : p_atk_q;

  pbs_damage_calc #(
    .HP_W     (HP_W),
    .PWR_W    (PWR_W),
    .STAT_W   (STAT_W),
    .DMG_SHIFT(DMG_SHIFT)
  ) u_dmg (
    .clk    (clk),
    .reset  (reset),
    .load_i (calc_en),
    .power_i(power_q),
    .atk_i  (atk_sel),
    .dmg_o  (dmg_w)
  );

  // Next-state and control. Whichever side just moved, the next LOAD is the
  // other side's: within a turn that is the second mover, across a turn
  // boundary it is the first mover again. The first-mover flag only decides
  // whether this APPLY closes a turn.
  always_comb begin
    state_d       = state_q;
    p_hp_d        = p_hp_q;
    e_hp_d        = e_hp_q;
    turn_d        = turn_q;
    enemy_first_d = enemy_first_q;
    load_ops      = 1'b0;
    take_move     = 1'b0;
    turn_next     = turn_q + TC_W'(1);

    case (state_q)
      IDLE, VICTORY, LOSS, DRAW: begin
        if (start) begin
          load_ops      = 1'b1;
          p_hp_d        = p_hp_init;
          e_hp_d        = e_hp_init;
          turn_d        = '0;
          enemy_first_d = (e_spd > p_spd);
          if (p_hp_init == '0) begin
            state_d = LOSS;
          end else if (e_hp_init == '0) begin
            state_d = VICTORY;
          end else if (e_spd > p_spd) begin
            state_d = LOAD_AM;
          end else begin
            state_d = LOAD_PM;
          end
        end
      end
      LOAD_PM: begin
        if (move_valid) begin
          take_move = 1'b1;
          state_d   = CALC_PH;
        end
      end
      CALC_PH: state_d = APPLY_AD;
      APPLY_AD: begin
        e_hp_d = hp_after_hit(e_hp_q, dmg_w);
        if (e_hp_q <= dmg_w) begin
          state_d = VICTORY;
        end else if (enemy_first_q) begin
          turn_d  = turn_next;
          state_d = (turn_next == TC_W'(MAX_TURNS)) ? DRAW : LOAD_AM;
        end else begin
          state_d = LOAD_AM;
        end
      end
      LOAD_AM: begin
        if (move_valid) begin
          take_move = 1'b1;
          state_d   = CALC_AH;
        end
      end
      CALC_AH: state_d = APPLY_PD;
      APPLY_PD: begin
        p_hp_d = hp_after_hit(p_hp_q, dmg_w);
        if (p_hp_q <= dmg_w) begin
          state_d = LOSS;
        end else if (!enemy_first_q) begin
          turn_d  = turn_next;
          state_d = (turn_next == TC_W'(MAX_TURNS)) ? DRAW : LOAD_PM;
        end else begin
          state_d = LOAD_PM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      p_hp_q        <= '0;
      e_hp_q        <= '0;
      turn_q        <= '0;
      enemy_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_hp_q        <= p_hp_d;
      e_hp_q        <= e_hp_d;
      turn_q        <= turn_d;
      enemy_first_q <= enemy_first_d;
    end
  end

  // Operand latches: only meaningful once loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load_ops) begin
      p_atk_q <= p_atk;
      e_atk_q <= e_atk;
    end
    if (take_move) begin
      power_q <= move_power;
    end
  end

  assign move_ready    = (state_q == LOAD_PM) || (state_q == LOAD_AM);
  assign dmg_valid     = (state_q == APPLY_AD) || (state_q == APPLY_PD);
  assign dmg_to_player = (state_q == APPLY_PD);
  assign dmg           = dmg_w;
  assign p_hp          = p_hp_q;
  assign e_hp          = e_hp_q;
  assign turn_cnt      = turn_q;
  assign busy          = !is_settled(state_q);
  assign victory       = (state_q == VICTORY);
  assign loss          = (state_q == LOSS);
  assign draw          = (state_q == DRAW);

endmodule

// File: tb/tb_pbs_battle_engine.sv
// -----------------------------------------------------------------------------
// tb_pbs_battle_engine
// Two engines: A with default parameters, B with DMG_SHIFT=0 and MAX_TURNS=2.
// Damage events are checked by a scoreboard fed when each move is driven;
// single-move battles come from a vector table, multi-cycle cases are
// written out by hand. All driving and sampling happens on the falling edge.
// -----------------------------------------------------------------------------
module tb_pbs_battle_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] p_hp_init = '0, e_hp_init = '0;
  logic [5:0] p_atk = '0, e_atk = '0, p_spd = '0, e_spd = '0;

  logic       start_a = 1'b0, mv_a = 1'b0;
  logic [5:0] pw_a = '0;
  logic       a_move_ready, a_dmg_valid, a_dmg_to_player;
  logic       a_busy, a_victory, a_loss, a_draw;
  logic [7:0] a_p_hp, a_e_hp, a_dmg;
  logic [5:0] a_turn_cnt;

  logic       start_b = 1'b0, mv_b = 1'b0;
  logic [5:0] pw_b = '0;
  logic       b_move_ready, b_dmg_valid, b_dmg_to_player;
  logic       b_busy, b_victory, b_loss, b_draw;
  logic [7:0] b_p_hp, b_e_hp, b_dmg;
  logic [1:0] b_turn_cnt;

  always #5 clk = ~clk;

  pbs_battle_engine u_a (
    .clk(clk), .reset(reset), .start(start_a),
    .p_hp_init(p_hp_init), .e_hp_init(e_hp_init),
    .p_atk(p_atk), .e_atk(e_atk), .p_spd(p_spd), .e_spd(e_spd),
    .move_valid(mv_a), .move_power(pw_a), .move_ready(a_move_ready),
    .p_hp(a_p_hp), .e_hp(a_e_hp),
    .dmg_valid(a_dmg_valid), .dmg(a_dmg), .dmg_to_player(a_dmg_to_player),
    .turn_cnt(a_turn_cnt), .busy(a_busy), .victory(a_victory),
    .loss(a_loss), .draw(a_draw)
  );

  pbs_battle_engine #(.DMG_SHIFT(0), .MAX_TURNS(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b),
    .p_hp_init(p_hp_init), .e_hp_init(e_hp_init),
    .p_atk(p_atk), .e_atk(e_atk), .p_spd(p_spd), .e_spd(e_spd),
    .move_valid(mv_b), .move_power(pw_b), .move_ready(b_move_ready),
    .p_hp(b_p_hp), .e_hp(b_e_hp),
    .dmg_valid(b_dmg_valid), .dmg(b_dmg), .dmg_to_player(b_dmg_to_player),
    .turn_cnt(b_turn_cnt), .busy(b_busy), .victory(b_victory),
    .loss(b_loss), .draw(b_draw)
  );

  typedef struct {
    logic [7:0] dmg;
    logic       tp;
  } exp_t;

  typedef struct {
    int php, ehp, patk, eatk, pspd, espd, pw;
    int exp_dmg;
    bit exp_tp;
    int exp_hp;
    bit exp_vic, exp_loss;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_move_ready : a_move_ready;
  endfunction

  function automatic logic dv(input bit b);
    return b ? b_dmg_valid : a_dmg_valid;
  endfunction

  // Scoreboard consumers.
  always @(negedge clk) begin
    exp_t e;
    if (a_dmg_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb_a unexpected dmg event: dmg %0d", a_dmg);
      end else begin
        e = q_a.pop_front();
        chk("sb_a dmg", a_dmg, e.dmg);
        chk("sb_a dmg_to_player", a_dmg_to_player, e.tp);
      end
    end
    if (b_dmg_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb_b unexpected dmg event: dmg %0d", b_dmg);
      end else begin
        e = q_b.pop_front();
        chk("sb_b dmg", b_dmg, e.dmg);
        chk("sb_b dmg_to_player", b_dmg_to_player, e.tp);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic do_start(input bit b, input int php, input int ehp, input int patk,
                          input int eatk, input int pspd, input int espd);
    p_hp_init = php[7:0]; e_hp_init = ehp[7:0];
    p_atk = patk[5:0]; e_atk = eatk[5:0]; p_spd = pspd[5:0]; e_spd = espd[5:0];
    if (b) start_b = 1'b1; else start_a = 1'b1;
    cyc(1);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // One handshake, then CALC and APPLY; returns on the cycle HP is updated.
  task automatic do_move(input bit b, input int pw, input int ed, input bit etp);
    exp_t e;
    int   k;
    k = 0;
    while (rdy(b) !== 1'b1 && k < 10) begin
      cyc(1);
      k++;
    end
    chk("move_ready before move", rdy(b), 1);
    e.dmg = ed[7:0];
    e.tp  = etp;
    if (b) q_b.push_back(e); else q_a.push_back(e);
    if (b) begin mv_b = 1'b1; pw_b = pw[5:0]; end
    else   begin mv_a = 1'b1; pw_a = pw[5:0]; end
    cyc(1);
    mv_a = 1'b0; mv_b = 1'b0;
    chk("move_ready low in CALC", rdy(b), 0);
    chk("dmg_valid low in CALC", dv(b), 0);
    cyc(1);
    chk("dmg_valid in APPLY", dv(b), 1);
    cyc(1);
    chk("dmg_valid one cycle", dv(b), 0);
  endtask

  task automatic chk_a_reset_vals(input string tag);
    chk({tag, " p_hp"}, a_p_hp, 0);
    chk({tag, " e_hp"}, a_e_hp, 0);
    chk({tag, " dmg"}, a_dmg, 0);
    chk({tag, " turn_cnt"}, a_turn_cnt, 0);
    chk({tag, " flags"}, {a_move_ready, a_dmg_valid, a_dmg_to_player,
                          a_busy, a_victory, a_loss, a_draw}, 0);
  endtask

  vec_t vecs[9];

  initial begin
    //          php ehp patk eatk ps es  pw  dmg tp  hp  vic loss
    vecs[0] = '{20, 10,  8,  8,  5, 3, 10, 10, 0,  0, 1, 0};
    vecs[1] = '{20, 10,  8,  8,  5, 9,  4,  4, 1, 16, 0, 0};
    vecs[2] = '{20, 10,  1,  8,  5, 5,  1,  1, 0,  9, 0, 0};
    vecs[3] = '{20, 10,  8,  8,  5, 3,  0,  0, 0, 10, 0, 0};
    vecs[4] = '{20, 200, 63, 8,  5, 3, 63, 255, 0, 0, 1, 0};
    vecs[5] = '{5,  50,  8, 40,  5, 9, 10, 50, 1,  0, 0, 1};
    vecs[6] = '{20, 11,  8,  8,  5, 3, 10, 10, 0,  1, 0, 0};
    vecs[7] = '{30, 30,  7,  8,  2, 2,  9,  7, 0, 23, 0, 0};
    vecs[8] = '{30, 30,  8,  1,  1, 2,  7,  1, 1, 29, 0, 0};

    // Reset state.
    cyc(2);
    reset = 1'b0;
    chk_a_reset_vals("reset");
    chk("reset b flags", {b_busy, b_victory, b_loss, b_draw, b_dmg_valid}, 0);
    chk("reset b dmg", b_dmg, 0);

    // Single-move battles from the table.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      do_start(0, vecs[i].php, vecs[i].ehp, vecs[i].patk, vecs[i].eatk,
               vecs[i].pspd, vecs[i].espd);
      chk("busy after start", a_busy, 1);
      do_move(0, vecs[i].pw, vecs[i].exp_dmg, vecs[i].exp_tp);
      if (vecs[i].exp_tp) begin
        chk("vec target p_hp", a_p_hp, vecs[i].exp_hp);
        chk("vec other e_hp", a_e_hp, vecs[i].ehp);
      end else begin
        chk("vec target e_hp", a_e_hp, vecs[i].exp_hp);
        chk("vec other p_hp", a_p_hp, vecs[i].php);
      end
      chk("vec victory", a_victory, vecs[i].exp_vic);
      chk("vec loss", a_loss, vecs[i].exp_loss);
      chk("vec busy", a_busy, !(vecs[i].exp_vic || vecs[i].exp_loss));
    end

    // Zero starting HP goes straight to an end state.
    do_reset();
    do_start(0, 0, 10, 8, 8, 5, 3);
    chk("zero p_hp loss", {a_loss, a_victory, a_busy, a_move_ready}, 4'b1000);
    do_start(0, 10, 0, 8, 8, 5, 3);
    chk("zero e_hp victory", {a_loss, a_victory, a_busy}, 3'b010);
    do_start(0, 0, 0, 8, 8, 5, 3);
    chk("both zero loss", {a_loss, a_victory}, 2'b10);

    // Multi-turn battle on A, then hold of the end state.
    do_reset();
    do_start(0, 20, 10, 8, 8, 5, 3);
    do_move(0, 4, 4, 0);
    chk("mt e_hp 1", a_e_hp, 6);
    chk("mt turn 0", a_turn_cnt, 0);
    do_move(0, 4, 4, 1);
    chk("mt p_hp 1", a_p_hp, 16);
    chk("mt turn 1", a_turn_cnt, 1);
    do_move(0, 4, 4, 0);
    do_move(0, 4, 4, 1);
    chk("mt p_hp 2", a_p_hp, 12);
    chk("mt turn 2", a_turn_cnt, 2);
    do_move(0, 4, 4, 0);
    chk("mt victory", a_victory, 1);
    cyc(3);
    chk("hold victory", {a_victory, a_busy}, 2'b10);
    chk("hold hp", {a_p_hp, a_e_hp}, {8'd12, 8'd0});
    chk("hold turn", a_turn_cnt, 2);

    // Restart from VICTORY with enemy first; start while busy is ignored.
    do_start(0, 20, 10, 8, 8, 5, 9);
    chk("restart turn cleared", a_turn_cnt, 0);
    chk("restart flags", {a_busy, a_victory, a_move_ready}, 3'b101);
    do_start(0, 99, 99, 1, 1, 9, 1);
    chk("busy start ignored p_hp", a_p_hp, 20);
    chk("busy start ignored ready", a_move_ready, 1);
    do_move(0, 4, 4, 1);
    chk("enemy first p_hp", a_p_hp, 16);

    // Reset in CALC_PH, after a start that arrives in LOAD_PM.
    do_reset();
    do_start(0, 20, 10, 8, 8, 5, 3);
    do_start(0, 77, 77, 8, 8, 5, 3);
    chk("start in LOAD_PM ignored", {a_p_hp, a_move_ready}, {8'd20, 1'b1});
    mv_a = 1'b1; pw_a = 6'd10;
    cyc(1);
    mv_a = 1'b0;
    chk("in CALC", {a_busy, a_move_ready, a_dmg_valid}, 3'b100);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_a_reset_vals("reset in CALC");
    cyc(2);
    chk("idle after CALC reset", {a_busy, a_dmg_valid}, 0);

    // Reset wins over start.
    p_hp_init = 8'd20; e_hp_init = 8'd10;
    reset = 1'b1; start_a = 1'b1;
    cyc(1);
    reset = 1'b0; start_a = 1'b0;
    chk_a_reset_vals("reset over start");

    // B: saturation with no shift.
    do_start(1, 100, 100, 63, 63, 5, 3);
    do_move(1, 63, 255, 0);
    chk("b sat e_hp", b_e_hp, 0);
    chk("b sat victory", b_victory, 1);

    // B: draw after two full turns of zero-power moves.
    do_start(1, 100, 100, 8, 8, 5, 3);
    do_move(1, 0, 0, 0);
    chk("b zero hp unchanged", b_e_hp, 100);
    do_move(1, 0, 0, 1);
    chk("b turn 1", b_turn_cnt, 1);
    chk("b busy mid", {b_busy, b_draw}, 2'b10);
    do_move(1, 0, 0, 0);
    do_move(1, 0, 0, 1);
    chk("b draw", {b_draw, b_busy, b_victory, b_loss}, 4'b1000);
    chk("b draw turn", b_turn_cnt, 2);
    chk("b draw hp", {b_p_hp, b_e_hp}, {8'd100, 8'd100});
    cyc(2);
    chk("b draw hold", b_draw, 1);

    chk("sb_a drained", q_a.size(), 0);
    chk("sb_b drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/pbs_battle_engine.md
PBS_BATTLE_ENGINE -- requirements
Module: pbs_battle_engine

Interface
REQ-001 SHALL have parameter HP_W, default 8, HP register width.
REQ-002 SHALL have parameter PWR_W, default 6, move-power width.
REQ-003 SHALL have parameter STAT_W, default 6, attack/speed stat width.
REQ-004 SHALL have parameter DMG_SHIFT, default 3, right-shift applied to power*attack.
REQ-005 SHALL have parameter MAX_TURNS, default 63, full turns before draw; turn_cnt width = clog2(MAX_TURNS+1).
REQ-006 SHALL provide clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL provide reset  in  1  synchronous, active-high reset.
REQ-008 SHALL provide start  in  1  begin battle; honoured only in IDLE, VICTORY, LOSS, DRAW.
REQ-009 SHALL provide p_hp_init, e_hp_init  in  HP_W  starting HP, sampled on accepted start.
REQ-010 SHALL provide p_atk, e_atk, p_spd, e_spd  in  STAT_W  stats, sampled on accepted start.
REQ-011 SHALL provide move_valid  in  1 / move_power  in  PWR_W / move_ready  out  1  move handshake.
REQ-012 SHALL provide p_hp, e_hp  out  HP_W  current HP.
REQ-013 SHALL provide dmg_valid  out  1 / dmg  out  HP_W / dmg_to_player  out  1  damage event.
REQ-014 SHALL provide turn_cnt  out  turn count; busy, victory, loss, draw  out  1.

Function
REQ-015 States SHALL be IDLE, LOAD_PM, CALC_PH, APPLY_AD, LOAD_AM, CALC_AH, APPLY_PD, VICTORY, LOSS, DRAW.
REQ-016 Accepted start SHALL latch HPs/stats, clear turn_cnt, and select first mover: enemy if e_spd > p_spd, else player (tie to player).
REQ-017 Cycle after accepted start SHALL be LOAD_PM/LOAD_AM per first mover, except: p_hp_init==0 -> LOSS, else e_hp_init==0 -> VICTORY.
REQ-018 move_ready SHALL be 1 only in LOAD_PM/LOAD_AM; move accepted when move_valid && move_ready, power latched, next state CALC_*; else remain.
REQ-019 CALC_* SHALL register dmg = (power*atk_of_mover) >> DMG_SHIFT, full-width product, no intermediate truncation.
REQ-020 Damage SHALL be floored to 1 when power!=0 and shifted result is 0; power==0 yields 0.
REQ-021 Damage SHALL saturate to 2^HP_W-1.
REQ-022 APPLY_* SHALL pulse dmg_valid for exactly one cycle with dmg and dmg_to_player (1 in APPLY_PD).
REQ-023 APPLY_* SHALL write target HP = (hp > dmg) ? hp-dmg : 0, visible on the following cycle.
REQ-024 After APPLY: target HP reaches 0 -> VICTORY (enemy) or LOSS (player).
REQ-025 After APPLY, non-zero HP, second mover not yet acted -> second mover's LOAD.
REQ-026 After APPLY of second mover: turn_cnt increments; if new value == MAX_TURNS -> DRAW, else first mover's LOAD.
REQ-027 Per move latency SHALL be handshake cycle + 2 cycles (CALC, APPLY).
REQ-028 VICTORY/LOSS/DRAW SHALL hold their flag and HP values until accepted start or reset.
REQ-029 busy SHALL be 1 in every state except IDLE, VICTORY, LOSS, DRAW.
REQ-030 start while busy SHALL be ignored with no state change.
REQ-031 Outputs SHALL be registered or decoded from registered state only.

Reset
REQ-032 reset SHALL force IDLE from any state, including mid-handshake.
REQ-033 Reset values: p_hp=0, e_hp=0, dmg=0, turn_cnt=0, all 1-bit outputs 0.
REQ-034 reset SHALL take priority over start in the same cycle.

Structure
REQ-035 Package pbs_pkg SHALL hold the state enum and parameter defaults.
REQ-036 Damage arithmetic (REQ-019..021) SHALL be a sub-module pbs_damage_calc.
REQ-037 Only the state register and latched operands SHALL be in pbs_battle_engine.

Verification
REQ-038 Defaults; start p_hp=20,e_hp=10,p_atk=8,e_atk=8,p_spd=5,e_spd=3; player power 10 -> dmg=10, e_hp=0, VICTORY after APPLY_AD.
REQ-039 e_spd=9 > p_spd=5 -> move_ready first in LOAD_AM; enemy power 4, atk 8 -> dmg=4 to player.
REQ-040 Power 1, atk 1 -> dmg=1 (floor); power 0 -> dmg=0, HP unchanged, dmg_valid still pulses.
REQ-041 HP_W=8, power 63, atk 63, shift 0 -> dmg=255 saturated, target HP 0.
REQ-042 MAX_TURNS=2, both powers 0 -> DRAW after 2nd full turn, turn_cnt=2.
REQ-043 reset asserted in CALC_PH -> IDLE next cycle, outputs at reset values; start in LOAD_PM ignored.
